// File: rtl/booth_radix4_seq_mult.sv
// Sequential radix-4 Booth multiplier: retires two multiplier bits per cycle behind a
// start/done handshake, with runtime signed/unsigned mode and a held product register.
module booth_radix4_seq_mult #(
  parameter int unsigned N = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [N-1:0]     i_a,
  input  logic [N-1:0]     i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [2*N-1:0]   o_product
);

  localparam int unsigned S  = N / 2 + 1;
  localparam int unsigned CW = $clog2(S);
  localparam int unsigned AW = 2 * N + 4;
  localparam logic [AW-1:0] One = AW'(1);

  generate
    if ((N % 2) != 0 || N < 4) begin : g_bad_n
      $error("booth_radix4_seq_mult: N must be even and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [N+1:0]     m_q, m_d;
  logic [N+2:0]     b_q, b_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    step_q, step_d;
  logic [2*N-1:0]   prod_q, prod_d;

  logic [AW-1:0]    m_wide, pp, pp_sh, acc_sum;

  // The multiplicand is already extended per mode, so sign-extending it further is exact.
  assign m_wide = {{(N+2){m_q[N+1]}}, m_q};

  always_comb begin
    pp = '0;
    unique case (b_q[2:0])
      3'b000, 3'b111: pp = '0;
      3'b001, 3'b010: pp = m_wide;
      3'b011:         pp = m_wide << 1;
      3'b100:         pp = ~(m_wide << 1) + One;
      3'b101, 3'b110: pp = ~m_wide + One;
      default:        pp = '0;
    endcase
  end

  assign pp_sh   = pp << {step_q, 1'b0};
  assign acc_sum = acc_q + pp_sh;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    b_d     = b_q;
    acc_d   = acc_q;
    step_d  = step_q;
    prod_d  = prod_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          m_d     = i_signed ? {{2{i_a[N-1]}}, i_a} : {2'b00, i_a};
          // Implicit zero appended below the multiplier LSB; the triplet is always b_q[2:0].
          b_d     = {(i_signed ? {{2{i_b[N-1]}}, i_b} : {2'b00, i_b}), 1'b0};
          acc_d   = '0;
          step_d  = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        acc_d  = acc_sum;
        b_d    = b_q >> 2;
        step_d = step_q + CW'(1);
        if (step_q == CW'(S - 1)) begin
          prod_d  = acc_sum[2*N-1:0];
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      m_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      step_q  <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      prod_q  <= prod_d;
    end
  end

  assign o_busy    = (state_q != StIdle);
  assign o_done    = (state_q == StDone);
  assign o_product = prod_q;

endmodule

// File: tb/tb_booth_radix4_seq_mult.sv
// Scoreboard bench for booth_radix4_seq_mult at N=8 and N=16: expected products are queued
// at request acceptance and compared when o_done pulses.
module tb_booth_radix4_seq_mult;

  localparam int unsigned S8  = 5;
  localparam int unsigned S16 = 9;

  logic        clk;
  logic        reset_n;

  logic        st8, sg8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  logic        st16, sg16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int acc_cyc8 = 0;

  logic [15:0] q8[$];
  logic [31:0] q16[$];
  logic [15:0] held8  = '0;
  logic [31:0] held16 = '0;

  booth_radix4_seq_mult #(.N(8)) dut8 (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_start   (st8),
    .i_signed  (sg8),
    .i_a       (a8),
    .i_b       (b8),
    .o_busy    (busy8),
    .o_done    (done8),
    .o_product (p8)
  );

  booth_radix4_seq_mult #(.N(16)) dut16 (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_start   (st16),
    .i_signed  (sg16),
    .i_a       (a16),
    .i_b       (b16),
    .o_busy    (busy16),
    .o_done    (done16),
    .o_product (p16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model8(input logic s, input logic [7:0] a,
                                         input logic [7:0] b);
    logic signed [15:0] sa, sb, sp;
    if (s) begin
      sa = {{8{a[7]}}, a};
      sb = {{8{b[7]}}, b};
      sp = sa * sb;
      return sp;
    end
    return {8'h00, a} * {8'h00, b};
  endfunction

  function automatic logic [31:0] model16(input logic s, input logic [15:0] a,
                                          input logic [15:0] b);
    logic signed [31:0] sa, sb, sp;
    if (s) begin
      sa = {{16{a[15]}}, a};
      sb = {{16{b[15]}}, b};
      sp = sa * sb;
      return sp;
    end
    return {16'h0000, a} * {16'h0000, b};
  endfunction

  // Holds i_start with the operands until the DUT is idle at an edge, then releases it.
  task automatic start8(input logic s, input logic [7:0] a, input logic [7:0] b);
    int guard = 0;
    @(negedge clk);
    st8 = 1'b1; sg8 = s; a8 = a; b8 = b;
    while (busy8 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (busy8) begin
      check_eq("accept8", busy8, 0);
      st8 = 1'b0;
    end else begin
      q8.push_back(model8(s, a, b));
      @(posedge clk);
      #1;
      acc_cyc8 = cyc;
      st8 = 1'b0;
    end
  endtask

  task automatic start16(input logic s, input logic [15:0] a, input logic [15:0] b);
    int guard = 0;
    @(negedge clk);
    st16 = 1'b1; sg16 = s; a16 = a; b16 = b;
    while (busy16 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (busy16) begin
      check_eq("accept16", busy16, 0);
      st16 = 1'b0;
    end else begin
      q16.push_back(model16(s, a, b));
      @(posedge clk);
      #1;
      st16 = 1'b0;
    end
  endtask

  task automatic wait_done8(output int edges);
    edges = 0;
    while (!done8 && edges < 40) begin
      @(posedge clk);
      edges++;
      #1;
    end
    if (!done8) check_eq("timeout8", done8, 1);
  endtask

  task automatic wait_done16(output int edges);
    edges = 0;
    while (!done16 && edges < 40) begin
      @(posedge clk);
      edges++;
      #1;
    end
    if (!done16) check_eq("timeout16", done16, 1);
  endtask

  task automatic drain();
    int guard = 0;
    while ((q8.size() != 0 || q16.size() != 0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_eq("drain", q8.size() + q16.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!reset_n) held8 = '0;
    else if (done8) begin
      if (q8.size() == 0) check_eq("spurious_done8", done8, 0);
      else check_eq("prod8", p8, q8.pop_front());
      held8 = p8;
    end else check_eq("hold8", p8, held8);
  end

  always @(negedge clk) begin
    if (!reset_n) held16 = '0;
    else if (done16) begin
      if (q16.size() == 0) check_eq("spurious_done16", done16, 0);
      else check_eq("prod16", p16, q16.pop_front());
      held16 = p16;
    end else check_eq("hold16", p16, held16);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  c8[7]  = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h55, 8'hAA};
    logic [15:0] c16[5] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000};
    int lat, c1;

    reset_n = 1'b0;
    st8 = 0; sg8 = 0; a8 = '0; b8 = '0;
    st16 = 0; sg16 = 0; a16 = '0; b16 = '0;
    #2;
    check_eq("rst_busy8", busy8, 0);
    check_eq("rst_done8", done8, 0);
    check_eq("rst_prod8", p8, 0);
    check_eq("rst_busy16", busy16, 0);
    check_eq("rst_prod16", p16, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Signed min * min, with latency measured as the edge that samples o_done.
    start8(1'b1, 8'h80, 8'h80);
    wait_done8(lat);
    check_eq("lat8", lat + 1, S8 + 1);
    check_eq("t1_prod", p8, 16'h4000);

    start8(1'b0, 8'hFF, 8'hFF);
    wait_done8(lat);
    check_eq("t2_unsigned", p8, 16'hFE01);
    start8(1'b1, 8'hFF, 8'hFF);
    wait_done8(lat);
    check_eq("t2_signed", p8, 16'h0001);

    // Second request held through busy: accepted only after the first returns to idle.
    start8(1'b1, 8'h7F, 8'h80);
    c1 = acc_cyc8;
    start8(1'b0, 8'h12, 8'h34);
    check_eq("b2b_spacing8", acc_cyc8 - c1, S8 + 2);
    check_eq("t3_first", p8, 16'hC080);
    wait_done8(lat);
    check_eq("t3_second", p8, 16'h03A8);

    // Abort at the third CALC edge.
    start8(1'b0, 8'h55, 8'h33);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("abort_busy", busy8, 0);
    check_eq("abort_done", done8, 0);
    check_eq("abort_prod", p8, 0);
    q8.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    start8(1'b0, 8'h55, 8'h33);
    wait_done8(lat);
    check_eq("t4_after_abort", p8, 16'h10EF);

    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 7; i++)
        for (int j = 0; j < 7; j++)
          start8(1'(m), c8[i], c8[j]);
    for (int k = 0; k < 1500; k++)
      start8(1'($urandom), 8'($urandom), 8'($urandom));
    drain();

    start16(1'b1, 16'h8000, 16'h8000);
    wait_done16(lat);
    check_eq("lat16", lat + 1, S16 + 1);
    check_eq("t6_minmin", p16, 32'h4000_0000);
    start16(1'b0, 16'hFFFF, 16'hFFFF);
    wait_done16(lat);
    check_eq("t6_umax", p16, 32'hFFFE_0001);

    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++)
          start16(1'(m), c16[i], c16[j]);
    for (int k = 0; k < 1600; k++)
      start16(1'($urandom), 16'($urandom), 16'($urandom));
    drain();

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
